// File: rtl/array_feeder.sv
// array_feeder: upstream stage for the 5x5 systolic cell array.
// Buffers north-edge beats in a small FIFO, steps the array one beat per cycle,
// sequences drain (flush) and clear/preset commands.
// Optional feature macro: ARRAY_FEEDER_SKEW_EN (wavefront skew on lanes 1..4).
// Ports:
//   clock, reset                 rising-edge clock, synchronous active-high reset
//   s_valid/s_ready/s_in/s_ou    upstream beat handshake and lane data
//   flush, cmd_clear, cmd_preset single-cycle requests
//   arr_in, arr_ou               array edge lanes (registered)
//   arr_enable, arr_set          array step enable and set pulse (registered)
//   arr_reset                    reset OR registered clear pulse
//   busy, drain_done             status; drain_done pulses with the last zero beat
module array_feeder #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned ROWS       = 5
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       s_valid,
  output logic       s_ready,
  input  logic [4:0] s_in,
  input  logic [4:0] s_ou,
  input  logic       flush,
  input  logic       cmd_clear,
  input  logic       cmd_preset,
  output logic [4:0] arr_in,
  output logic [4:0] arr_ou,
  output logic       arr_enable,
  output logic       arr_set,
  output logic       arr_reset,
  output logic       busy,
  output logic       drain_done
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;
`ifdef ARRAY_FEEDER_SKEW_EN
  // Extra cycles flush the deepest skew lane as well.
  localparam int unsigned DrainLen = ROWS + 4;
`else
  localparam int unsigned DrainLen = ROWS;
`endif
  localparam int unsigned DrainW = $clog2(DrainLen + 1);

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   count_q, count_d;
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [9:0]        mem_q [FIFO_DEPTH];
  logic [DrainW-1:0] drain_cnt_q, drain_cnt_d;
  logic              flush_pend_q, flush_pend_d;
  logic [4:0]        beat_in_q, beat_ou_q;
  logic              en_q, set_q, clr_q, done_q;
  logic              en_d, set_d, clr_d, done_d;
  logic [4:0]        beat_in_d, beat_ou_d;
  logic              push, pop, full, flush_req, start_drain, cmd_ok;

  assign full    = (count_q == CntW'(FIFO_DEPTH));
  assign s_ready = !full && (state_q != StDrain);
  assign push    = s_valid && s_ready;
  assign pop     = (state_q == StRun) && (count_q != '0);
  assign count_d = count_q + CntW'(push) - CntW'(pop);
  assign flush_req = flush_pend_q | flush;
  assign cmd_ok  = (state_q == StIdle) && (count_q == '0);

  always_comb begin
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    start_drain = 1'b0;
    done_d      = 1'b0;
    unique case (state_q)
      StIdle: begin
        // IDLE -> RUN on the registered count, giving the two-cycle latency.
        if (count_q != '0) begin
          state_d = StRun;
        end else if (flush_req && !push) begin
          state_d     = StDrain;
          start_drain = 1'b1;
        end
      end
      StRun: begin
        if (count_d == '0) begin
          if (flush_req) begin
            state_d     = StDrain;
            start_drain = 1'b1;
          end else begin
            state_d = StIdle;
          end
        end
      end
      StDrain: begin
        drain_cnt_d = drain_cnt_q - DrainW'(1);
        if (drain_cnt_q == DrainW'(1)) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
    if (start_drain) begin
      drain_cnt_d = DrainW'(DrainLen);
    end
    flush_pend_d = flush_req & ~start_drain;
  end

  always_comb begin
    beat_in_d = '0;
    beat_ou_d = '0;
    if (pop) begin
      {beat_in_d, beat_ou_d} = mem_q[rd_ptr_q];
    end
    en_d  = pop | (state_q == StDrain);
    // Clear has priority over preset; both dropped outside empty IDLE.
    clr_d = cmd_clear & cmd_ok;
    set_d = cmd_preset & ~cmd_clear & cmd_ok;
  end

  always_ff @(posedge clock) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {s_in, s_ou};
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= StIdle;
      count_q      <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      drain_cnt_q  <= '0;
      flush_pend_q <= 1'b0;
      beat_in_q    <= '0;
      beat_ou_q    <= '0;
      en_q         <= 1'b0;
      set_q        <= 1'b0;
      clr_q        <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      wr_ptr_q     <= wr_ptr_q + PtrW'(push);
      rd_ptr_q     <= rd_ptr_q + PtrW'(pop);
      drain_cnt_q  <= drain_cnt_d;
      flush_pend_q <= flush_pend_d;
      beat_in_q    <= beat_in_d;
      beat_ou_q    <= beat_ou_d;
      en_q         <= en_d;
      set_q        <= set_d;
      clr_q        <= clr_d;
      done_q       <= done_d;
    end
  end

`ifdef ARRAY_FEEDER_SKEW_EN
  logic [4:0] skew_in, skew_ou;

  assign skew_in[0] = beat_in_q[0];
  assign skew_ou[0] = beat_ou_q[0];

  // Lane j runs through j stages that advance only on enabled array steps.
  for (genvar j = 1; j < 5; j++) begin : g_skew
    localparam int unsigned W = j;
    logic [W-1:0] in_sr_q, ou_sr_q;

    always_ff @(posedge clock) begin
      if (reset) begin
        in_sr_q <= '0;
        ou_sr_q <= '0;
      end else if (en_q) begin
        in_sr_q <= W'({in_sr_q, beat_in_q[j]});
        ou_sr_q <= W'({ou_sr_q, beat_ou_q[j]});
      end
    end

    assign skew_in[j] = in_sr_q[W-1];
    assign skew_ou[j] = ou_sr_q[W-1];
  end

  // Held skew contents are hidden while the array is not stepping.
  assign arr_in = en_q ? skew_in : '0;
  assign arr_ou = en_q ? skew_ou : '0;
`else
  assign arr_in = beat_in_q;
  assign arr_ou = beat_ou_q;
`endif

  assign arr_enable = en_q;
  assign arr_set    = set_q;
  assign arr_reset  = reset | clr_q;
  assign busy       = (state_q != StIdle) || (count_q != '0);
  assign drain_done = done_q;

endmodule

// File: tb/tb_array_feeder.sv
// Self-checking bench for array_feeder: per-cycle vector table, scoreboarded
// streaming/flush sequences, reset during drain, and (skew build) lane timing.
module tb_array_feeder;

`ifdef ARRAY_FEEDER_SKEW_EN
  localparam int DRAIN_LEN = 9;
`else
  localparam int DRAIN_LEN = 5;
`endif

  logic       clock = 1'b0;
  logic       reset;
  logic       s_valid, s_ready;
  logic [4:0] s_in, s_ou;
  logic       flush, cmd_clear, cmd_preset;
  logic [4:0] arr_in, arr_ou;
  logic       arr_enable, arr_set, arr_reset, busy, drain_done;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  array_feeder #(.FIFO_DEPTH(4), .ROWS(5)) dut (
    .clock      (clock),
    .reset      (reset),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_in       (s_in),
    .s_ou       (s_ou),
    .flush      (flush),
    .cmd_clear  (cmd_clear),
    .cmd_preset (cmd_preset),
    .arr_in     (arr_in),
    .arr_ou     (arr_ou),
    .arr_enable (arr_enable),
    .arr_set    (arr_set),
    .arr_reset  (arr_reset),
    .busy       (busy),
    .drain_done (drain_done)
  );

  always #5 clock = ~clock;

  initial forever begin
    @(posedge clock);
    cyc++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Inputs change and outputs are read 2 time units after the rising edge.
  task automatic step();
    @(posedge clock);
    #2;
  endtask

  task automatic idle_inputs();
    s_valid    = 1'b0;
    s_in       = '0;
    s_ou       = '0;
    flush      = 1'b0;
    cmd_clear  = 1'b0;
    cmd_preset = 1'b0;
  endtask

  function automatic logic [15:0] outvec();
    return {s_ready, arr_in, arr_ou, arr_enable, arr_set, arr_reset, busy, drain_done};
  endfunction

  typedef struct packed {
    logic        v;
    logic [4:0]  i;
    logic [4:0]  o;
    logic        clr;
    logic        pre;
    logic [15:0] exp;  // {rdy, in, ou, en, set, rst, busy, done} after the edge
  } vec_t;

`ifndef ARRAY_FEEDER_SKEW_EN
  logic [9:0] sb_q[$];
  bit         sb_on = 1'b0;
  int         en_cnt = 0;
  int         first_cyc = -1;
  int         last_cyc = -1;

  // Monitor samples 1 unit after the edge, ahead of the stimulus process.
  initial forever begin
    logic [9:0] exp;
    @(posedge clock);
    #1;
    if (sb_on && arr_enable) begin
      en_cnt++;
      if (first_cyc < 0) first_cyc = cyc;
      last_cyc = cyc;
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_extra_beat: got in=%b ou=%b with nothing expected", arr_in, arr_ou);
      end else begin
        exp = sb_q.pop_front();
        check("sb_beat", {22'd0, arr_in, arr_ou}, {22'd0, exp});
      end
    end
  end
`endif

  initial begin
    vec_t tbl [12];
    int   n;
    bit   seen;

    idle_inputs();
    reset = 1'b1;
    repeat (3) step();
    check("reset_outputs", {16'd0, outvec()}, {16'd0, 16'b1_00000_00000_0_0_1_0_0});
    reset = 1'b0;
    #1;
    check("post_reset_outputs", {16'd0, outvec()}, {16'd0, 16'b1_00000_00000_0_0_0_0_0});

`ifndef ARRAY_FEEDER_SKEW_EN
    tbl[0]  = '{1'b1, 5'b10101, 5'b00011, 1'b0, 1'b0, 16'b1_00000_00000_0_0_0_1_0};
    tbl[1]  = '{1'b0, 5'b00000, 5'b00000, 1'b0, 1'b0, 16'b1_00000_00000_0_0_0_1_0};
    tbl[2]  = '{1'b0, 5'b00000, 5'b00000, 1'b0, 1'b0, 16'b1_10101_00011_1_0_0_0_0};
    tbl[3]  = '{1'b0, 5'b00000, 5'b00000, 1'b0, 1'b0, 16'b1_00000_00000_0_0_0_0_0};
    tbl[4]  = '{1'b0, 5'b00000, 5'b00000, 1'b1, 1'b1, 16'b1_00000_00000_0_0_1_0_0};
    tbl[5]  = '{1'b0, 5'b00000, 5'b00000, 1'b0, 1'b1, 16'b1_00000_00000_0_1_0_0_0};
    tbl[6]  = '{1'b0, 5'b00000, 5'b00000, 1'b0, 1'b0, 16'b1_00000_00000_0_0_0_0_0};
    tbl[7]  = '{1'b1, 5'b00001, 5'b10000, 1'b0, 1'b0, 16'b1_00000_00000_0_0_0_1_0};
    tbl[8]  = '{1'b0, 5'b00000, 5'b00000, 1'b0, 1'b1, 16'b1_00000_00000_0_0_0_1_0};
    tbl[9]  = '{1'b0, 5'b00000, 5'b00000, 1'b0, 1'b1, 16'b1_00001_10000_1_0_0_0_0};
    tbl[10] = '{1'b0, 5'b00000, 5'b00000, 1'b1, 1'b0, 16'b1_00000_00000_0_0_1_0_0};
    tbl[11] = '{1'b0, 5'b00000, 5'b00000, 1'b0, 1'b0, 16'b1_00000_00000_0_0_0_0_0};

    for (int r = 0; r < 12; r++) begin
      s_valid    = tbl[r].v;
      s_in       = tbl[r].i;
      s_ou       = tbl[r].o;
      cmd_clear  = tbl[r].clr;
      cmd_preset = tbl[r].pre;
      step();
      check($sformatf("vec_row%0d", r), {16'd0, outvec()}, {16'd0, tbl[r].exp});
    end
    idle_inputs();

    // Ten back-to-back beats: no s_ready drop, ten consecutive enables.
    sb_on = 1'b1;
    en_cnt = 0;
    first_cyc = -1;
    for (int k = 0; k < 10; k++) begin
      s_valid = 1'b1;
      s_in    = 5'($urandom);
      s_ou    = 5'($urandom);
      check("stream_ready", {31'd0, s_ready}, 32'd1);
      sb_q.push_back({s_in, s_ou});
      step();
    end
    idle_inputs();
    n = 0;
    while ((sb_q.size() != 0 || busy) && n < 30) begin
      step();
      n++;
    end
    check("stream_in_time", {31'd0, n < 30}, 32'd1);
    step();
    check("stream_enables", en_cnt, 10);
    check("stream_contiguous", last_cyc - first_cyc, 9);

    // Three beats then flush: data, then zero beats, then drain_done.
    en_cnt = 0;
    first_cyc = -1;
    for (int k = 0; k < 3; k++) begin
      s_valid = 1'b1;
      s_in    = 5'(k + 1);
      s_ou    = 5'(5'b11000 >> k);
      sb_q.push_back({s_in, s_ou});
      step();
    end
    idle_inputs();
    flush = 1'b1;
    for (int k = 0; k < DRAIN_LEN; k++) sb_q.push_back(10'd0);
    step();
    flush = 1'b0;
    n = 0;
    while (!drain_done && n < 40) begin
      step();
      n++;
    end
    check("flush_done_seen", {31'd0, drain_done}, 32'd1);
    check("flush_busy_low", {31'd0, busy}, 32'd0);
    check("flush_sb_empty", sb_q.size(), 0);
    step();
    check("flush_done_one_cycle", {31'd0, drain_done}, 32'd0);
    check("flush_enables", en_cnt, 3 + DRAIN_LEN);
    check("flush_contiguous", last_cyc - first_cyc, 2 + DRAIN_LEN);

    // Flush from an empty IDLE still drains fully.
    en_cnt = 0;
    flush = 1'b1;
    for (int k = 0; k < DRAIN_LEN; k++) sb_q.push_back(10'd0);
    step();
    flush = 1'b0;
    check("idle_flush_ready_low", {31'd0, s_ready}, 32'd0);
    n = 0;
    while (!drain_done && n < 40) begin
      step();
      n++;
    end
    check("idle_flush_done", {31'd0, drain_done}, 32'd1);
    check("idle_flush_enables", en_cnt, DRAIN_LEN);
    step();

    // Reset in the second drain cycle aborts without drain_done.
    sb_on = 1'b0;
    sb_q.delete();
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("drain_busy", {31'd0, busy}, 32'd1);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    check("abort_outputs", {16'd0, outvec()}, {16'd0, 16'b1_00000_00000_0_0_0_0_0});
    seen = 1'b0;
    for (int k = 0; k < 12; k++) begin
      step();
      seen = seen | drain_done | arr_enable | busy;
    end
    check("abort_stays_idle", {31'd0, seen}, 32'd0);
`else
    // Skewed wavefront: lane j of an all-ones beat shows in cycle t+2+j.
    s_valid = 1'b1;
    s_in    = 5'b11111;
    s_ou    = 5'b11111;
    step();
    idle_inputs();
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("skew_t1_in", {27'd0, arr_in}, 32'd0);
    for (int k = 2; k <= 12; k++) begin
      logic [4:0] e;
      logic [4:0] one;
      one = 5'b00001;
      e = (k <= 6) ? (one << (k - 2)) : 5'b00000;
      step();
      check($sformatf("skew_in_t%0d", k), {27'd0, arr_in}, {27'd0, e});
      check($sformatf("skew_ou_t%0d", k), {27'd0, arr_ou}, {27'd0, e});
      check($sformatf("skew_en_t%0d", k), {31'd0, arr_enable}, {31'd0, k <= 11});
      check($sformatf("skew_done_t%0d", k), {31'd0, drain_done}, {31'd0, k == 11});
    end
    check("skew_idle", {31'd0, busy}, 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
